// File: rtl/barrier_retire_trace_queue_if.sv
// rtl/barrier_retire_trace_queue_if.sv - trace drain port for the barrier retire queue
//
// Purpose: groups the valid/ready drain handshake and the head-entry payload.
// Ports (signals):
//   trace_valid      head entry valid               (master -> slave)
//   trace_ready      consumer accepts head entry    (slave  -> master)
//   trace_pc         head entry PC                  (master -> slave)
//   trace_wf_bitmap  head entry wavefront bitmap    (master -> slave)
//   trace_wf_count   popcount of head bitmap        (master -> slave)
//   trace_timestamp  timestamp of head entry        (master -> slave)
interface barrier_retire_trace_queue_if #(
  parameter int WF_PER_CU = 40,
  parameter int TS_WIDTH  = 32
);
  logic                 trace_valid;
  logic                 trace_ready;
  logic [31:0]          trace_pc;
  logic [WF_PER_CU-1:0] trace_wf_bitmap;
  logic [5:0]           trace_wf_count;
  logic [TS_WIDTH-1:0]  trace_timestamp;

  modport master (
    output trace_valid, trace_pc, trace_wf_bitmap, trace_wf_count, trace_timestamp,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_pc, trace_wf_bitmap, trace_wf_count, trace_timestamp,
    output trace_ready
  );
endinterface

// File: rtl/barrier_retire_trace_queue.sv
// rtl/barrier_retire_trace_queue.sv - timestamped FIFO of barrier-retire events with drop accounting
//
// Purpose: timestamps each barrier-retire event, stores its PC, wavefront bitmap and
// popcount in a circular buffer and drains it first-word-fall-through to the trace
// consumer. The barrier stage cannot stall, so events arriving while full are dropped
// and counted instead of back-pressured.
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-low reset
//   retire_en         barrier retire event this cycle
//   retire_pc         PC of the completing barrier instruction
//   retire_wf_bitmap  wavefronts released by the event
//   clear_overflow    clears the sticky overflow flag
//   trace             drain port (master side), head entry + valid/ready
//   queue_level       occupied entries
//   overflow          sticky, at least one event dropped
//   drop_count        dropped events, saturating at 16'hFFFF
module barrier_retire_trace_queue #(
  parameter int DEPTH     = 8,
  parameter int WF_PER_CU = 40,
  parameter int TS_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         retire_en,
  input  logic [31:0]                  retire_pc,
  input  logic [WF_PER_CU-1:0]         retire_wf_bitmap,
  input  logic                         clear_overflow,
  barrier_retire_trace_queue_if.master trace,
  output logic [$clog2(DEPTH):0]       queue_level,
  output logic                         overflow,
  output logic [15:0]                  drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [31:0]          mem_pc    [DEPTH];
  logic [WF_PER_CU-1:0] mem_bitmap[DEPTH];
  logic [5:0]           mem_count [DEPTH];
  logic [TS_WIDTH-1:0]  mem_ts    [DEPTH];

  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [AW:0]          level;
  logic [TS_WIDTH-1:0]  timestamp;
  logic                 overflow_q;
  logic [15:0]          drops;

  logic                 head_valid;
  logic                 is_full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [5:0]           push_count;

  assign head_valid = (level != '0);
  assign is_full    = (level == FULL_LEVEL);
  assign pop        = head_valid & trace.trace_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts the event.
  assign push       = retire_en & (~is_full | pop);
  assign drop       = retire_en & is_full & ~pop;
  assign push_count = 6'($countones(retire_wf_bitmap));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]     <= '0;
        mem_bitmap[i] <= '0;
        mem_count[i]  <= '0;
        mem_ts[i]     <= '0;
      end
    end else if (push) begin
      mem_pc[wr_ptr]     <= retire_pc;
      mem_bitmap[wr_ptr] <= retire_wf_bitmap;
      mem_count[wr_ptr]  <= push_count;
      mem_ts[wr_ptr]     <= timestamp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (pop && !push) level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timestamp  <= '0;
      overflow_q <= 1'b0;
      drops      <= '0;
    end else begin
      timestamp <= timestamp + TS_WIDTH'(1);
      // A drop takes priority over a simultaneous clear so no loss goes unreported.
      if (drop) begin
        overflow_q <= 1'b1;
        if (drops != 16'hFFFF) drops <= drops + 16'd1;
      end else if (clear_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign trace.trace_valid     = head_valid;
  assign trace.trace_pc        = head_valid ? mem_pc[rd_ptr]     : '0;
  assign trace.trace_wf_bitmap = head_valid ? mem_bitmap[rd_ptr] : '0;
  assign trace.trace_wf_count  = head_valid ? mem_count[rd_ptr]  : '0;
  assign trace.trace_timestamp = head_valid ? mem_ts[rd_ptr]     : '0;

  assign queue_level = level;
  assign overflow    = overflow_q;
  assign drop_count  = drops;

endmodule

// File: tb/tb_barrier_retire_trace_queue.sv
// tb/tb_barrier_retire_trace_queue.sv - self-checking bench for barrier_retire_trace_queue
module tb_barrier_retire_trace_queue;

  localparam int DEPTH = 8;
  localparam int WF    = 40;
  localparam int TSW   = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          retire_en;
  logic [31:0]   retire_pc;
  logic [WF-1:0] retire_wf_bitmap;
  logic          clear_overflow;
  logic [3:0]    queue_level;
  logic          overflow;
  logic [15:0]   drop_count;

  int checks = 0;
  int errors = 0;

  barrier_retire_trace_queue_if #(.WF_PER_CU(WF), .TS_WIDTH(TSW)) trace_if ();

  barrier_retire_trace_queue #(.DEPTH(DEPTH), .WF_PER_CU(WF), .TS_WIDTH(TSW)) dut (
    .clk              (clk),
    .rst              (rst_n),
    .retire_en        (retire_en),
    .retire_pc        (retire_pc),
    .retire_wf_bitmap (retire_wf_bitmap),
    .clear_overflow   (clear_overflow),
    .trace            (trace_if.master),
    .queue_level      (queue_level),
    .overflow         (overflow),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an unbounded queue capped at DEPTH, plus counters.
  typedef struct {
    logic [31:0]    pc;
    logic [WF-1:0]  bm;
    int             cnt;
    logic [TSW-1:0] ts;
  } entry_t;

  entry_t         mq[$];
  logic [TSW-1:0] m_ts;
  bit             m_ovf;
  int             m_drops;

  function automatic int popcnt(input logic [WF-1:0] v);
    int n = 0;
    for (int i = 0; i < WF; i++) if (v[i]) n++;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ts    = '0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      bit     do_pop;
      bit     do_push;
      entry_t e;
      do_pop  = (mq.size() > 0) && trace_if.trace_ready;
      do_push = retire_en && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc  = retire_pc;
        e.bm  = retire_wf_bitmap;
        e.cnt = popcnt(retire_wf_bitmap);
        e.ts  = m_ts;
        mq.push_back(e);
      end
      if (retire_en && !do_push) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end else if (clear_overflow) begin
        m_ovf = 1'b0;
      end
      m_ts = m_ts + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      bit v;
      v = mq.size() > 0;
      check("valid", trace_if.trace_valid, v);
      check("pc",    trace_if.trace_pc,        v ? mq[0].pc : 32'h0);
      check("bm",    trace_if.trace_wf_bitmap, v ? mq[0].bm : 40'h0);
      check("count", trace_if.trace_wf_count,  v ? mq[0].cnt : 0);
      check("ts",    trace_if.trace_timestamp, v ? mq[0].ts : 32'h0);
      check("level", queue_level, mq.size());
      check("ovf",   overflow, m_ovf);
      check("drops", drop_count, m_drops);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [WF-1:0] bm);
    retire_en        = 1'b1;
    retire_pc        = pc;
    retire_wf_bitmap = bm;
    tick();
    retire_en        = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    retire_en        = 1'b0;
    retire_pc        = '0;
    retire_wf_bitmap = '0;
    clear_overflow   = 1'b0;
    trace_if.trace_ready = 1'b0;
    tick();
    @(negedge clk);
    check("rst_valid", trace_if.trace_valid, 0);
    check("rst_level", queue_level, 0);
    check("rst_drops", drop_count, 0);
    check("rst_ovf",   overflow, 0);
    tick();
    rst_n = 1'b1;

    // Single event pushed while the timestamp reads 5.
    repeat (5) tick();
    push_one(32'h100, 40'h00_0000_000F);
    @(negedge clk);
    check("single_pc",    trace_if.trace_pc, 32'h100);
    check("single_count", trace_if.trace_wf_count, 4);
    check("single_ts",    trace_if.trace_timestamp, 5);
    check("single_level", queue_level, 1);
    trace_if.trace_ready = 1'b1;
    tick();
    trace_if.trace_ready = 1'b0;
    @(negedge clk);
    check("single_drained", queue_level, 0);

    // Fill to full, then three drops.
    tick();
    for (int i = 0; i < 11; i++) push_one(32'h200 + i, 40'h1 << i);
    @(negedge clk);
    check("fill_level", queue_level, 8);
    check("fill_ovf",   overflow, 1);
    check("fill_drops", drop_count, 3);
    tick();
    trace_if.trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("drain_order", trace_if.trace_pc, 32'h200 + i);
      tick();
    end
    trace_if.trace_ready = 1'b0;
    @(negedge clk);
    check("drain_empty", queue_level, 0);
    check("drain_ovf_sticky", overflow, 1);

    // Full queue with simultaneous push and pop.
    tick();
    for (int i = 0; i < 8; i++) push_one(32'h300 + i, 40'hFF);
    retire_en            = 1'b1;
    retire_pc            = 32'h3AA;
    retire_wf_bitmap     = 40'h3;
    trace_if.trace_ready = 1'b1;
    tick();
    retire_en            = 1'b0;
    trace_if.trace_ready = 1'b0;
    @(negedge clk);
    check("pushpop_level", queue_level, 8);
    check("pushpop_drops", drop_count, 3);
    tick();
    trace_if.trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("pushpop_order", trace_if.trace_pc, (i == 7) ? 32'h3AA : 32'h301 + i);
      tick();
    end
    trace_if.trace_ready = 1'b0;

    // Popcount bounds.
    push_one(32'h400, {WF{1'b1}});
    push_one(32'h404, 40'h0);
    @(negedge clk);
    check("pop_all_ones", trace_if.trace_wf_count, 40);
    tick();
    trace_if.trace_ready = 1'b1;
    tick();
    trace_if.trace_ready = 1'b0;
    @(negedge clk);
    check("zero_valid", trace_if.trace_valid, 1);
    check("zero_count", trace_if.trace_wf_count, 0);
    check("zero_pc",    trace_if.trace_pc, 32'h404);
    tick();
    trace_if.trace_ready = 1'b1;
    tick();
    trace_if.trace_ready = 1'b0;

    // Saturation: fill, then 65540 drops; the final drop collides with clear_overflow.
    for (int i = 0; i < 8; i++) push_one(32'h500 + i, 40'h5);
    retire_en = 1'b1;
    retire_pc = 32'h5FF;
    repeat (65539) tick();
    clear_overflow = 1'b1;
    tick();
    retire_en      = 1'b0;
    clear_overflow = 1'b0;
    @(negedge clk);
    check("sat_drops", drop_count, 16'hFFFF);
    check("collide_ovf", overflow, 1);
    tick();
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    @(negedge clk);
    check("clear_ovf", overflow, 0);
    check("clear_keeps_drops", drop_count, 16'hFFFF);

    // Asynchronous reset mid-burst at level 5.
    tick();
    trace_if.trace_ready = 1'b1;
    repeat (3) tick();
    trace_if.trace_ready = 1'b0;
    @(negedge clk);
    check("pre_reset_level", queue_level, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", trace_if.trace_valid, 0);
    check("async_level", queue_level, 0);
    check("async_drops", drop_count, 0);
    tick();
    rst_n = 1'b1;
    push_one(32'h600, 40'h7);
    @(negedge clk);
    check("post_reset_valid", trace_if.trace_valid, 1);
    check("post_reset_pc",    trace_if.trace_pc, 32'h600);
    check("post_reset_count", trace_if.trace_wf_count, 3);
    check("post_reset_ts",    trace_if.trace_timestamp, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
